// File: rtl/sim_run_sequencer.sv
// sim_run_sequencer: run controller for simulation top levels.
// Sequences DUT reset, run window, watchdog and drain, then reports status.
module sim_run_sequencer #(
    parameter int CW           = 32,
    parameter int RST_CYCLES   = 8,
    parameter int RUN_LIMIT    = 300,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dut_done,
    input  logic          dut_fail,
    output logic          dut_reset_l,
    output logic          run_en,
    output logic          busy,
    output logic [CW-1:0] cycle_cnt,
    output logic [1:0]    status,
    output logic          finished,
    output logic [2:0]    phase
);

    localparam int TW = 32;

    localparam logic [TW-1:0] RST_LOAD   = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] DRAIN_LOAD = TW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(RUN_LIMIT - 1);

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_tmr;

    logic       w_last;
    logic       w_run_exit;
    logic [1:0] w_exit_status;

    assign w_last     = (cycle_cnt == LAST_CNT);
    assign w_run_exit = dut_fail | dut_done | w_last;

    // Exit cause: fail beats done, and any event beats the watchdog.
    always_comb begin
        w_exit_status = ST_TIMEOUT;
        if (dut_fail) begin
            w_exit_status = ST_FAIL;
        end else if (dut_done) begin
            w_exit_status = ST_PASS;
        end
    end

    // Run-phase FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            dut_reset_l <= 1'b0;
            run_en      <= 1'b0;
            busy        <= 1'b0;
            cycle_cnt   <= '0;
            status      <= ST_NONE;
            finished    <= 1'b0;
            phase       <= S_IDLE;
        end else begin
            finished <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_RST;
                        r_tmr       <= RST_LOAD;
                        cycle_cnt   <= '0;
                        status      <= ST_NONE;
                        dut_reset_l <= 1'b0;
                        run_en      <= 1'b0;
                        busy        <= 1'b1;
                        phase       <= S_RST;
                    end
                end
                S_RST: begin
                    if (r_tmr == '0) begin
                        r_state     <= S_RUN;
                        dut_reset_l <= 1'b1;
                        run_en      <= 1'b1;
                        cycle_cnt   <= '0;
                        phase       <= S_RUN;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (w_run_exit) begin
                        r_state <= S_DRAIN;
                        r_tmr   <= DRAIN_LOAD;
                        status  <= w_exit_status;
                        run_en  <= 1'b0;
                        phase   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_tmr == '0) begin
                        r_state  <= S_DONE;
                        busy     <= 1'b0;
                        finished <= 1'b1;
                        phase    <= S_DONE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    dut_reset_l <= 1'b0;
                    run_en      <= 1'b0;
                    busy        <= 1'b0;
                    phase       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_sequencer.sv
// tb_sim_run_sequencer: directed table, corner sequences and random
// stimulus checked against a time-based model of the run schedule.
module tb_sim_run_sequencer;

    localparam int CW = 32;
    localparam int R  = 4;
    localparam int L  = 10;
    localparam int D  = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          dut_done;
    logic          dut_fail;
    logic          dut_reset_l;
    logic          run_en;
    logic          busy;
    logic [CW-1:0] cycle_cnt;
    logic [1:0]    status;
    logic          finished;
    logic [2:0]    phase;

    int checks;
    int errors;

    sim_run_sequencer #(
        .CW(CW), .RST_CYCLES(R), .RUN_LIMIT(L), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .dut_done(dut_done), .dut_fail(dut_fail),
        .dut_reset_l(dut_reset_l), .run_en(run_en), .busy(busy),
        .cycle_cnt(cycle_cnt), .status(status),
        .finished(finished), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a run is described by the edge offset since start (m_t)
    // and the offset of the edge that ended RUN (m_end, -1 if not yet).
    int         m_seq;
    int         m_t;
    int         m_end;
    logic [1:0] m_st;

    function automatic int cur_ph();
        if (m_seq == 0) return 0;
        if (m_t < R) return 1;
        if (m_end < 0) return 2;
        if (m_t < m_end + D) return 3;
        return 4;
    endfunction

    function automatic void model_edge(logic r, logic s, logic d, logic f);
        int p;
        p = cur_ph();
        if (r) begin
            m_seq = 0;
            m_st  = 2'b00;
        end else if ((p == 0 || p == 4) && s) begin
            m_seq = 1;
            m_t   = 0;
            m_end = -1;
            m_st  = 2'b00;
        end else if (m_seq != 0) begin
            if (p == 2) begin
                if (f) begin
                    m_st = 2'b10; m_end = m_t + 1;
                end else if (d) begin
                    m_st = 2'b01; m_end = m_t + 1;
                end else if (m_t - R == L - 1) begin
                    m_st = 2'b11; m_end = m_t + 1;
                end
            end
            m_t++;
        end
    endfunction

    function automatic logic [40:0] model_out();
        int          p;
        logic [31:0] c;
        logic [1:0]  s;
        p = cur_ph();
        c = '0;
        s = 2'b00;
        if (p == 2) c = 32'(m_t - R);
        if (p >= 3) begin
            c = 32'(m_end - R);
            s = m_st;
        end
        return {3'(p), 1'(p >= 2), 1'(p == 2), 1'(p >= 1 && p <= 3),
                c, s, 1'(p == 4 && m_t == m_end + D)};
    endfunction

    function automatic logic [40:0] act_out();
        return {phase, dut_reset_l, run_en, busy, cycle_cnt, status, finished};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic d,
                        input logic f);
        reset    = r;
        start    = s;
        dut_done = d;
        dut_fail = f;
        @(posedge clk);
        model_edge(r, s, d, f);
        #1;
        chk("model", 64'(act_out()), 64'(model_out()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Start a run and advance to the first RUN cycle (cycle_cnt=0).
    task automatic to_run();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(R);
        chk("run_entry_phase", 64'(phase), 64'd2);
    endtask

    typedef struct packed {
        logic        r, s, d, f;
        logic [2:0]  ph;
        logic        rl, en, bz;
        logic [31:0] cnt;
        logic [1:0]  st;
        logic        fin;
    } vec_t;

    function automatic vec_t v(logic r, logic s, logic d, logic f,
                               logic [2:0] ph, logic rl, logic en,
                               logic bz, int cnt, logic [1:0] st,
                               logic fin);
        vec_t x;
        x.r = r; x.s = s; x.d = d; x.f = f;
        x.ph = ph; x.rl = rl; x.en = en; x.bz = bz;
        x.cnt = 32'(cnt); x.st = st; x.fin = fin;
        return x;
    endfunction

    vec_t tbl[17];

    initial begin
        checks   = 0;
        errors   = 0;
        m_seq    = 0;
        m_t      = 0;
        m_end    = -1;
        m_st     = 2'b00;
        reset    = 1'b1;
        start    = 1'b0;
        dut_done = 1'b0;
        dut_fail = 1'b0;

        tbl[0]  = v(1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 2'b00, 0);
        tbl[1]  = v(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 2'b00, 0);
        tbl[2]  = v(1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 2'b00, 0);
        tbl[3]  = v(0, 1, 0, 0, 3'd1, 0, 0, 1, 0, 2'b00, 0);
        tbl[4]  = v(0, 0, 0, 0, 3'd1, 0, 0, 1, 0, 2'b00, 0);
        tbl[5]  = v(0, 1, 0, 0, 3'd1, 0, 0, 1, 0, 2'b00, 0);
        tbl[6]  = v(0, 0, 1, 1, 3'd1, 0, 0, 1, 0, 2'b00, 0);
        tbl[7]  = v(0, 0, 0, 0, 3'd2, 1, 1, 1, 0, 2'b00, 0);
        tbl[8]  = v(0, 0, 0, 0, 3'd2, 1, 1, 1, 1, 2'b00, 0);
        tbl[9]  = v(0, 1, 0, 0, 3'd2, 1, 1, 1, 2, 2'b00, 0);
        tbl[10] = v(0, 0, 0, 0, 3'd2, 1, 1, 1, 3, 2'b00, 0);
        tbl[11] = v(0, 0, 0, 0, 3'd2, 1, 1, 1, 4, 2'b00, 0);
        tbl[12] = v(0, 0, 0, 0, 3'd2, 1, 1, 1, 5, 2'b00, 0);
        tbl[13] = v(0, 0, 1, 0, 3'd3, 1, 0, 1, 6, 2'b01, 0);
        tbl[14] = v(0, 1, 0, 1, 3'd3, 1, 0, 1, 6, 2'b01, 0);
        tbl[15] = v(0, 0, 0, 0, 3'd4, 1, 0, 0, 6, 2'b01, 1);
        tbl[16] = v(0, 0, 0, 0, 3'd4, 1, 0, 0, 6, 2'b01, 0);

        #2;
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].f);
            chk($sformatf("table[%0d]", i), 64'(act_out()),
                64'({tbl[i].ph, tbl[i].rl, tbl[i].en, tbl[i].bz,
                     tbl[i].cnt, tbl[i].st, tbl[i].fin}));
        end

        // Watchdog timeout; done during DRAIN must not alter status.
        to_run();
        idle(L - 1);
        chk("pre_timeout_cnt", 64'(cycle_cnt), 64'(L - 1));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("timeout_status", 64'(status), 64'd3);
        chk("timeout_cnt", 64'(cycle_cnt), 64'(L));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("timeout_fin", 64'(finished), 64'd1);
        chk("timeout_hold", 64'(status), 64'd3);
        idle(1);
        chk("fin_single", 64'(finished), 64'd0);

        // Simultaneous done and fail: fail wins.
        to_run();
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("both_status", 64'(status), 64'd2);
        chk("both_cnt", 64'(cycle_cnt), 64'd3);
        idle(D);
        chk("both_done_phase", 64'(phase), 64'd4);

        // Restart from DONE, then done in the first RUN cycle.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("restart_status", 64'(status), 64'd0);
        chk("restart_cnt", 64'(cycle_cnt), 64'd0);
        chk("restart_rl", 64'(dut_reset_l), 64'd0);
        idle(R);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("first_cycle_status", 64'(status), 64'd1);
        chk("first_cycle_cnt", 64'(cycle_cnt), 64'd1);
        idle(D);
        chk("first_cycle_fin", 64'(finished), 64'd1);

        // Done on the last allowed cycle beats timeout.
        to_run();
        idle(L - 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("last_cycle_status", 64'(status), 64'd1);
        chk("last_cycle_cnt", 64'(cycle_cnt), 64'(L));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Reset mid-run aborts without a finish pulse.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(R - 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("abort_pre_cnt", 64'(cycle_cnt), 64'd4);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("abort_out", 64'(act_out()), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk("abort_no_fin", 64'(finished), 64'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(1'(($urandom % 64) == 0), 1'(($urandom % 4) == 0),
                 1'(($urandom % 8) == 0), 1'(($urandom % 16) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
